// File: rtl/sort_unit_pipe_rtl.sv
// Three-stage pipelined 4-element odd-even merge sorting network with
// per-transaction direction, optional signed compare and val/rdy flow control.
module sort_unit_pipe_rtl #(
  parameter int unsigned NBITS  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0][NBITS-1:0] in_,
  input  logic                  in_dir,
  input  logic                  in_val,
  output logic                  in_rdy,
  output logic [3:0][NBITS-1:0] out,
  output logic                  out_val,
  input  logic                  out_rdy
);

  logic [3:0][NBITS-1:0] r_d1, r_d2, r_d3;
  logic                  r_dir1, r_dir2, r_dir3;
  logic                  r_v1, r_v2, r_v3;

  logic [3:0][NBITS-1:0] w_l1, w_l2, w_l3;
  logic                  w_adv1, w_adv2, w_adv3;

  function automatic logic f_gt(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  // True when a and b must exchange so that a ends up "first" for this direction.
  function automatic logic f_swap(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                  input logic dir);
    return dir ? f_gt(b, a) : f_gt(a, b);
  endfunction

  always_comb begin
    w_l1 = in_;
    if (f_swap(in_[0], in_[1], in_dir)) begin
      w_l1[0] = in_[1];
      w_l1[1] = in_[0];
    end
    if (f_swap(in_[2], in_[3], in_dir)) begin
      w_l1[2] = in_[3];
      w_l1[3] = in_[2];
    end
  end

  always_comb begin
    w_l2 = r_d1;
    if (f_swap(r_d1[0], r_d1[2], r_dir1)) begin
      w_l2[0] = r_d1[2];
      w_l2[2] = r_d1[0];
    end
    if (f_swap(r_d1[1], r_d1[3], r_dir1)) begin
      w_l2[1] = r_d1[3];
      w_l2[3] = r_d1[1];
    end
  end

  always_comb begin
    w_l3 = r_d2;
    if (f_swap(r_d2[1], r_d2[2], r_dir2)) begin
      w_l3[1] = r_d2[2];
      w_l3[2] = r_d2[1];
    end
  end

  // Bubble-collapsing advance chain: an empty stage always lets upstream move.
  always_comb begin
    w_adv3 = !r_v3 || out_rdy;
    w_adv2 = !r_v2 || w_adv3;
    w_adv1 = !r_v1 || w_adv2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d1   <= '0;
      r_dir1 <= 1'b0;
      r_v1   <= 1'b0;
    end else if (w_adv1) begin
      r_d1   <= w_l1;
      r_dir1 <= in_dir;
      r_v1   <= in_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d2   <= '0;
      r_dir2 <= 1'b0;
      r_v2   <= 1'b0;
    end else if (w_adv2) begin
      r_d2   <= w_l2;
      r_dir2 <= r_dir1;
      r_v2   <= r_v1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d3   <= '0;
      r_dir3 <= 1'b0;
      r_v3   <= 1'b0;
    end else if (w_adv3) begin
      r_d3   <= w_l3;
      r_dir3 <= r_dir2;
      r_v3   <= r_v2;
    end
  end

  assign in_rdy  = w_adv1;
  assign out     = r_d3;
  assign out_val = r_v3;

  logic w_unused;
  assign w_unused = r_dir3;

endmodule

// File: tb/tb_sort_unit_pipe_rtl.sv
// Scoreboard bench: an unsigned and a signed instance share stimulus; a monitor
// pops expected results whenever a result is consumed.
module tb_sort_unit_pipe_rtl;

  typedef logic [3:0][7:0] vec_t;
  typedef struct {
    vec_t d;
    int   acc;
    bit   lat;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vec_t in_v = '0;
  logic in_dir = 1'b0;
  logic in_val = 1'b0;
  logic out_rdy = 1'b1;
  logic rdy_u, rdy_s, oval_u, oval_s;
  vec_t out_u, out_s;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  ent_t qu[$];
  ent_t qs[$];

  sort_unit_pipe_rtl #(.NBITS(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(rst_n), .in_(in_v), .in_dir(in_dir), .in_val(in_val),
    .in_rdy(rdy_u), .out(out_u), .out_val(oval_u), .out_rdy(out_rdy)
  );

  sort_unit_pipe_rtl #(.NBITS(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(rst_n), .in_(in_v), .in_dir(in_dir), .in_val(in_val),
    .in_rdy(rdy_s), .out(out_s), .out_val(oval_s), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    return v;
  endfunction

  // Plain reference sort (bubble sort on integer keys), used for random traffic.
  function automatic vec_t ref_sort(input vec_t v, input logic dir, input bit sgn);
    int   k[4];
    vec_t r;
    int   t;
    for (int i = 0; i < 4; i++) k[i] = sgn ? int'($signed(v[i])) : int'(v[i]);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++)
        if (k[i] > k[i+1]) begin
          t = k[i]; k[i] = k[i+1]; k[i+1] = t;
        end
    for (int i = 0; i < 4; i++) r[i] = 8'(dir ? k[3-i] : k[i]);
    return r;
  endfunction

  // Drives one transaction, waiting (bounded) for in_rdy; expected pushed on accept.
  task automatic send(input vec_t v, input logic d, input vec_t eu, input vec_t es,
                      input bit lat);
    int waited = 0;
    @(negedge clk);
    in_v = v; in_dir = d; in_val = 1'b1;
    #1;
    while (!(rdy_u && rdy_s)) begin
      if (waited == 100) begin
        check("accept_timeout", 64'(rdy_u), 64'(1));
        in_val = 1'b0;
        return;
      end
      @(negedge clk); #1;
      waited++;
    end
    qu.push_back('{d: eu, acc: cyc, lat: lat});
    qs.push_back('{d: es, acc: cyc, lat: lat});
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  logic prev_stall = 1'b0;
  vec_t prev_out = '0;

  always @(negedge clk) begin
    ent_t e;
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 64'(out_u), 64'(prev_out));
      if (oval_u !== oval_s) check("val_agree", 64'(oval_s), 64'(oval_u));
      if (oval_u && out_rdy) begin
        if (qu.size() == 0) check("unexpected_u", 64'(out_u), 64'(0));
        else begin
          e = qu.pop_front();
          check("data_u", 64'(out_u), 64'(e.d));
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'(3));
        end
      end
      if (oval_s && out_rdy) begin
        if (qs.size() == 0) check("unexpected_s", 64'(out_s), 64'(0));
        else begin
          e = qs.pop_front();
          check("data_s", 64'(out_s), 64'(e.d));
        end
      end
      prev_stall = oval_u && !out_rdy;
      prev_out = out_u;
    end
  end

  initial begin
    vec_t v, a, b;
    logic d;
    #12;
    check("rst_out_val", 64'({oval_u, oval_s}), 64'(0));
    check("rst_out", 64'({out_u, out_s}), 64'(0));
    check("rst_in_rdy", 64'({rdy_u, rdy_s}), 64'(2'b11));
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(mk(3, 1, 4, 2), 1'b0, mk(1, 2, 3, 4), mk(1, 2, 3, 4), 1'b1);
    repeat (5) @(negedge clk);
    send(mk(7, 7, 0, 255), 1'b1, mk(255, 7, 7, 0), mk(7, 7, 0, 255), 1'b1);
    send(mk(9, 5, 5, 1), 1'b0, mk(1, 5, 5, 9), mk(1, 5, 5, 9), 1'b1);
    send(mk(8'h80, 8'h7F, 8'hFF, 8'h00), 1'b0,
         mk(8'h00, 8'h7F, 8'h80, 8'hFF), mk(8'h80, 8'hFF, 8'h00, 8'h7F), 1'b1);
    repeat (6) @(negedge clk);

    // Backpressure: three fill the pipe, the remaining two wait for out_rdy.
    out_rdy = 1'b0;
    send(mk(10, 20, 30, 40), 1'b1, mk(40, 30, 20, 10), mk(40, 30, 20, 10), 1'b0);
    send(mk(1, 2, 3, 4), 1'b0, mk(1, 2, 3, 4), mk(1, 2, 3, 4), 1'b0);
    send(mk(200, 100, 50, 0), 1'b0, mk(0, 50, 100, 200), mk(200, 0, 50, 100), 1'b0);
    fork
      begin
        send(mk(8, 8, 8, 8), 1'b1, mk(8, 8, 8, 8), mk(8, 8, 8, 8), 1'b0);
        send(mk(0, 129, 1, 128), 1'b1, mk(129, 128, 1, 0), mk(1, 0, 129, 128), 1'b0);
      end
      begin
        repeat (4) begin
          @(negedge clk); #1;
          check("full_in_rdy", 64'({rdy_u, rdy_s}), 64'(0));
        end
        @(negedge clk);
        out_rdy = 1'b1;
      end
    join
    repeat (6) @(negedge clk);

    // Reset with two transactions in flight.
    send(mk(50, 40, 30, 20), 1'b0, mk(20, 30, 40, 50), mk(20, 30, 40, 50), 1'b1);
    send(mk(1, 1, 2, 2), 1'b1, mk(2, 2, 1, 1), mk(2, 2, 1, 1), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_val", 64'({oval_u, oval_s}), 64'(0));
    check("midrst_out", 64'({out_u, out_s}), 64'(0));
    check("midrst_in_rdy", 64'({rdy_u, rdy_s}), 64'(2'b11));
    qu.delete(); qs.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(oval_u), 64'(0));
    send(mk(4, 3, 2, 1), 1'b0, mk(1, 2, 3, 4), mk(1, 2, 3, 4), 1'b1);
    repeat (5) @(negedge clk);

    // Back-to-back random traffic with full throughput.
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, 255));
      d = 1'($urandom_range(0, 1));
      a = ref_sort(v, d, 1'b0);
      b = ref_sort(v, d, 1'b1);
      send(v, d, a, b, 1'b1);
    end

    for (int w = 0; w < 50 && (qu.size() != 0 || qs.size() != 0); w++) @(negedge clk);
    #3;
    check("drain_u", 64'(qu.size()), 64'(0));
    check("drain_s", 64'(qs.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_unit_pipe_rtl.md
# sort_unit_pipe_rtl

Parametrised, fully pipelined 4-element sorting network with valid/ready flow control, per-transaction sort direction and optional signed comparison. It is the next generation of the single-stage flat sort unit: it does the complete 3-layer odd-even merge sort rather than only the first compare layer. Backpressure stalls the pipeline without dropping or duplicating data. It sits between a producer and consumer that both use the `val`/`rdy` convention.

## Interface
- `NBITS`, default 8: width of each element.
- `SIGNED`, default 0: 0 = unsigned compare; 1 = two's-complement compare.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset. Low clears all state immediately; release is synchronous to `clk` externally.
- `in_` in 4×NBITS: input elements, index 0 … 3.
- `in_dir` in 1: 0 = ascending (out[0] smallest); 1 = descending (out[0] largest). Sampled with `in_`.
- `in_val` in 1: input transaction valid.
- `in_rdy` out 1: unit can accept this cycle.
- `out` out 4×NBITS: sorted elements.
- `out_val` out 1: `out` holds a valid result.
- `out_rdy` in 1: consumer accepts `out` this cycle.

## Operation
- Compare-exchange `CE(a,b)` places the "lower" value at a.
  - Ascending: swap iff a > b.
  - Descending: swap iff a < b.
  - Equal values are not swapped.
  - Comparison uses the `SIGNED` interpretation over the full NBITS.
- Layer 1: CE(0,1), CE(2,3). Layer 2: CE(0,2), CE(1,3). Layer 3: CE(1,2).
- Three pipeline registers, each holding data, dir and a valid bit:
  - R1 = layer1(`in_`)
  - R2 = layer2(R1)
  - R3 = layer3(R2)
- `out` = R3 data; `out_val` = v3. Comparison is combinational in front of each register.
- Flow control uses bubble-collapsing advance signals:
  - adv3 = !v3 | `out_rdy`
  - adv2 = !v2 | adv3
  - adv1 = !v1 | adv2
  - `in_rdy` = adv1, combinational from `out_rdy` and the valid bits.
- Register updates:
  - When adv1: R1 loads and v1 <= `in_val`.
  - When adv2: R2 loads and v2 <= v1.
  - When adv3: R3 loads and v3 <= v2.
  - A stage not advancing holds its data and valid.
- Direction travels with the data. Adjacent transactions may use different directions with no flush.
- Transaction accepted when `in_val` & `in_rdy`. Result consumed when `out_val` & `out_rdy`.
- Data registers load unconditionally when their stage advances, even if the incoming valid is 0. Data under valid = 0 is don't-care.
- No internal state machine beyond the three valid bits. Transactions are never reordered or dropped.

## Timing
- Reset (`reset` low), asynchronous:
  - v1..v3 = 0, all data registers = 0, dir = 0.
  - `out` = 0, `out_val` = 0, `in_rdy` = 1.
- Latency: a transaction accepted in cycle t appears with `out_val` = 1 in cycle t+3, given no stall.
- Throughput: 1 transaction per cycle while `out_rdy` = 1.
- Capacity: 3 transactions in flight.
- Full stall: with `out_rdy` = 0 and v1 = v2 = v3 = 1, `in_rdy` = 0 in the same cycle. `out` is held stable while `out_val` & !`out_rdy`.
- Bubbles collapse: if any stage is empty, upstream stages advance even while `out_rdy` = 0.
- Simultaneous accept and consume when full: `out_rdy` = 1 makes `in_rdy` = 1 in the same cycle and the pipeline shifts by one.
- Reset asserted mid-operation:
  - All in-flight transactions are discarded and `out_val` falls immediately, without waiting for a clock.
  - After release, the first accepted input has full latency 3.
- `in_` and `in_dir` are only sampled when `in_val` & `in_rdy`. Changes while `in_rdy` = 0 have no effect.

## Test plan
- Basic ascending, NBITS = 8: `in_` = {3,1,4,2}, dir = 0 → 3 cycles later `out` = {1,2,3,4}, `out_val` pulses 1 cycle.
- Descending plus duplicates: `in_` = {7,7,0,255}, dir = 1 → `out` = {255,7,7,0}. Next-cycle input {9,5,5,1} with dir = 0 → `out` = {1,5,5,9} with no bubble.
- Signed mode, SIGNED = 1: `in_` = {0x80,0x7F,0xFF,0x00}, dir = 0 → `out` = {0x80,0xFF,0x00,0x7F}. The same input with SIGNED = 0 → {0x00,0x7F,0x80,0xFF}.
- Backpressure:
  - Stream 5 transactions with `out_rdy` = 0 → `in_rdy` drops after 3 accepted; `out` holds the first result stable.
  - Then set `out_rdy` = 1 → all 5 results emerge in order, one per cycle, with no loss or duplication.
- Reset mid-flight: 2 transactions in flight, pull `reset` low between edges → `out_val` = 0 and `out` = 0 immediately, `in_rdy` = 1. After release, a new input yields its result 3 cycles later.
- Throughput: 100 random back-to-back transactions, random dir, `out_rdy` = 1 → one result per cycle, each matching a reference sort.
